// File: rtl/kmap8.sv
// kmap8: registered 4-input K-map function (in: clk, rst, a, b, c, d; out: mux_in[3:0] pre-stage, out registered f)
module kmap8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  output logic [3:0] mux_in,
  output logic       out
);
  logic f;
  always_comb begin
    mux_in[0] = c ? 1'b1 : d;
    mux_in[1] = 1'b0;
    mux_in[2] = d ? 1'b0 : 1'b1;
    mux_in[3] = c ? d : 1'b0;
    f = mux_in[{a, b}];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) out <= 1'b0;
    else out <= f;
endmodule

// File: tb/tb_kmap8.sv
// tb_kmap8: directed self-checking bench for kmap8
module tb_kmap8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic [3:0] mux_in;
  logic out;
  int tests = 0;
  int fails = 0;
  logic [15:0] kmap = 16'h850E;
  logic [15:0] pre = {4'b1001, 4'b0101, 4'b0001, 4'b0100};
  kmap8 dut (.clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .mux_in(mux_in), .out(out));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask
  initial begin
    #1 chk("reset_out", {3'b0, out}, 4'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int v = 0; v < 16; v++) begin
      {a, b, c, d} = v[3:0];
      @(posedge clk);
      #1 chk($sformatf("sweep_%0d", v), {3'b0, out}, {3'b0, kmap[v]});
      @(negedge clk);
    end
    for (int v = 0; v < 4; v++) begin
      {c, d} = v[1:0];
      {a, b} = 2'(3 - v);
      #1 chk($sformatf("pre_cd%0d", v), mux_in, pre[v*4 +: 4]);
      {a, b} = 2'(v);
      #1 chk($sformatf("pre_ab_cd%0d", v), mux_in, pre[v*4 +: 4]);
    end
    @(negedge clk);
    {a, b, c, d} = 4'b1111;
    @(posedge clk);
    #1 chk("pre_rst_one", {3'b0, out}, 4'b1);
    #1 rst = 1'b1;
    #1 chk("async_clear", {3'b0, out}, 4'b0);
    chk("rst_mux_in", mux_in, 4'b1001);
    repeat (2) @(posedge clk);
    #1 chk("rst_hold", {3'b0, out}, 4'b0);
    @(negedge clk);
    {a, b, c, d} = 4'b0011;
    rst = 1'b0;
    #1 chk("release_wait", {3'b0, out}, 4'b0);
    @(posedge clk);
    #1 chk("release_cap", {3'b0, out}, 4'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      {a, b, c, d} = i[0] ? 4'b0100 : 4'b1000;
      #1 chk($sformatf("lat_pre_%0d", i), {3'b0, out}, i == 0 ? 4'b1 : {3'b0, i[0] ? 1'b1 : 1'b0});
      @(posedge clk);
      #1 chk($sformatf("lat_post_%0d", i), {3'b0, out}, {3'b0, ~i[0]});
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
